// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - Wishbone-classic GPIO bank with set/clear outputs, synchronised inputs and optional edge irq
// Optional feature macro: GPIO_BANK_IRQ_EN (edge interrupt registers and irq_o).
module gpio_bank #(
    parameter int unsigned        N_GPIO      = 8,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [N_GPIO-1:0]  OUT_RST     = '0
) (
    input  logic              clk_i,
    input  logic              rst_in,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic [2:0]        adr_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       dat_i,
    output logic [31:0]       dat_o,
    output logic              ack_o,
    input  logic [N_GPIO-1:0] gpi_i,
    output logic [N_GPIO-1:0] gpo_o,
    output logic [N_GPIO-1:0] gpoe_o,
    output logic              irq_o
);

    localparam logic [2:0] ADR_IN       = 3'd0;
    localparam logic [2:0] ADR_OUT      = 3'd1;
    localparam logic [2:0] ADR_DIR      = 3'd2;
    localparam logic [2:0] ADR_OUT_SET  = 3'd3;
    localparam logic [2:0] ADR_OUT_CLR  = 3'd4;
    localparam logic [2:0] ADR_IRQ_EN   = 3'd5;
    localparam logic [2:0] ADR_IRQ_EDGE = 3'd6;
    localparam logic [2:0] ADR_IRQ_STAT = 3'd7;

    // Pin-wide values are zero-extended onto the 32-bit bus without a
    // zero-width replication when N_GPIO is 32.
    function automatic logic [31:0] zext(input logic [N_GPIO-1:0] v);
        logic [31:0] r;
        r = '0;
        r[N_GPIO-1:0] = v;
        return r;
    endfunction

    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic [N_GPIO-1:0] out_q, out_d;
    logic [N_GPIO-1:0] dir_q, dir_d;
    logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [N_GPIO-1:0] sync_d [SYNC_STAGES];

    logic              req;
    logic              wr;
    logic [31:0]       wmask32;
    logic [N_GPIO-1:0] wmask;
    logic [N_GPIO-1:0] wbits;
    logic [N_GPIO-1:0] in_sync;
    logic [31:0]       rdata;

    // Bus request decode and byte-lane write mask
    always_comb begin
        req     = cyc_i & stb_i & ~ack_q;
        wr      = req & we_i;
        wmask32 = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
        wmask   = wmask32[N_GPIO-1:0];
        wbits   = dat_i[N_GPIO-1:0] & wmask;
        in_sync = sync_q[SYNC_STAGES-1];
    end

    // Input synchroniser chain: stage 0 samples the raw pins
    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_d[i] = '0;
        end
        sync_d[0] = gpi_i;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

`ifdef GPIO_BANK_IRQ_EN
    logic [N_GPIO-1:0] irq_en_q, irq_en_d;
    logic [N_GPIO-1:0] irq_edge_q, irq_edge_d;
    logic [N_GPIO-1:0] irq_stat_q, irq_stat_d;
    logic [N_GPIO-1:0] prev_q, prev_d;
    logic              irq_q, irq_d;
    logic [N_GPIO-1:0] rise;
    logic [N_GPIO-1:0] fall;
    logic [N_GPIO-1:0] hit;
    logic [N_GPIO-1:0] clr;

    // Edge detection and interrupt register updates; a new edge beats a same-cycle W1C
    always_comb begin
        prev_d     = in_sync;
        rise       = in_sync & ~prev_q;
        fall       = ~in_sync & prev_q;
        hit        = (irq_edge_q & rise) | (~irq_edge_q & fall);
        irq_en_d   = irq_en_q;
        irq_edge_d = irq_edge_q;
        clr        = '0;
        if (wr) begin
            case (adr_i)
                ADR_IRQ_EN:   irq_en_d   = (irq_en_q & ~wmask) | wbits;
                ADR_IRQ_EDGE: irq_edge_d = (irq_edge_q & ~wmask) | wbits;
                ADR_IRQ_STAT: clr        = wbits;
                default:      clr        = '0;
            endcase
        end
        irq_stat_d = (irq_stat_q & ~clr) | hit;
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    // Interrupt state registers
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            irq_en_q   <= '0;
            irq_edge_q <= '0;
            irq_stat_q <= '0;
            prev_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_edge_q <= irq_edge_d;
            irq_stat_q <= irq_stat_d;
            prev_q     <= prev_d;
            irq_q      <= irq_d;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    // Register read multiplexer; write-only and absent registers read zero
    always_comb begin
        rdata = '0;
        case (adr_i)
            ADR_IN:       rdata = zext(in_sync);
            ADR_OUT:      rdata = zext(out_q);
            ADR_DIR:      rdata = zext(dir_q);
            ADR_OUT_SET:  rdata = '0;
            ADR_OUT_CLR:  rdata = '0;
`ifdef GPIO_BANK_IRQ_EN
            ADR_IRQ_EN:   rdata = zext(irq_en_q);
            ADR_IRQ_EDGE: rdata = zext(irq_edge_q);
            ADR_IRQ_STAT: rdata = zext(irq_stat_q);
`endif
            default:      rdata = '0;
        endcase
    end

    // Output data/direction updates and the single-cycle ack with registered read data
    always_comb begin
        ack_d = req;
        dat_d = (req && !we_i) ? rdata : '0;
        out_d = out_q;
        dir_d = dir_q;
        if (wr) begin
            case (adr_i)
                ADR_OUT:     out_d = (out_q & ~wmask) | wbits;
                ADR_DIR:     dir_d = (dir_q & ~wmask) | wbits;
                ADR_OUT_SET: out_d = out_q | wbits;
                ADR_OUT_CLR: out_d = out_q & ~wbits;
                default:     out_d = out_q;
            endcase
        end
    end

    // Bus, output and synchroniser state registers
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            out_q <= OUT_RST;
            dir_q <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            out_q <= out_d;
            dir_q <= dir_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign ack_o  = ack_q;
    assign dat_o  = dat_q;
    assign gpo_o  = out_q;
    assign gpoe_o = dir_q;

endmodule

// File: tb/tb_gpio_bank.sv
// tb/tb_gpio_bank.sv - self-checking bench for gpio_bank against a behavioural register model
module tb_gpio_bank;

    localparam int          N    = 8;
    localparam int          SS   = 2;
    localparam logic [7:0]  ORST = 8'h3C;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [2:0]  adr;
    logic [3:0]  be;
    logic [31:0] wdat;
    logic [31:0] rdat;
    logic        ack;
    logic [7:0]  gpi, gpo, gpoe;
    logic        irq;

    gpio_bank #(.N_GPIO(N), .SYNC_STAGES(SS), .OUT_RST(ORST)) dut (
        .clk_i (clk),   .rst_in(rst_n), .cyc_i(cyc),  .stb_i(stb),
        .we_i  (we),    .adr_i (adr),   .be_i (be),   .dat_i(wdat),
        .dat_o (rdat),  .ack_o (ack),   .gpi_i(gpi),  .gpo_o(gpo),
        .gpoe_o(gpoe),  .irq_o (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int checks = 0;
    int fails  = 0;

    // Model state
    logic [7:0] out_m, dir_m, en_m, edge_m, stat_m;
    logic [7:0] pins_old, pins_new;
    int         chg;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lane_mask(input logic [3:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (b[i]) m[i*8 +: 8] = 8'hFF;
        return m[7:0];
    endfunction

    // A pin change becomes readable once it has passed SS synchroniser flops
    // and then been captured by a read request edge.
    function automatic logic [7:0] exp_in(input int e);
        return (e >= chg + SS + 1) ? pins_new : pins_old;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a, input int e);
        logic [31:0] r;
        r = '0;
        case (a)
            3'd0: r[7:0] = exp_in(e);
            3'd1: r[7:0] = out_m;
            3'd2: r[7:0] = dir_m;
`ifdef GPIO_BANK_IRQ_EN
            3'd5: r[7:0] = en_m;
            3'd6: r[7:0] = edge_m;
            3'd7: r[7:0] = stat_m;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic set_pins(input logic [7:0] v);
        while (cyc_n < chg + SS + 1) @(negedge clk);
        pins_old = pins_new;
        pins_new = v;
        gpi      = v;
        chg      = cyc_n;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = 0; stb = 0; we = 0; adr = 0; be = 0; wdat = 0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        out_m    = ORST;
        dir_m    = 0; en_m = 0; edge_m = 0; stat_m = 0;
        pins_old = 0;
        pins_new = gpi;
        chg      = cyc_n;
    endtask

    // One bus transaction, called and returning at a negedge.
    task automatic wb(input logic w, input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
        int         e;
        logic [7:0] m;
        logic [31:0] got;
        cyc = 1; stb = 1; we = w; adr = a; be = b; wdat = d;
        e = cyc_n + 1;
        @(negedge clk);
        check("ack_hi", {31'b0, ack}, 32'd1);
        got = rdat;
        cyc = 0; stb = 0;
        m = lane_mask(b) & d[7:0];
        if (!w) begin
            check($sformatf("rd%0d", a), got, exp_read(a, e));
        end else begin
            case (a)
                3'd1: out_m = (out_m & ~lane_mask(b)) | m;
                3'd2: dir_m = (dir_m & ~lane_mask(b)) | m;
                3'd3: out_m = out_m | m;
                3'd4: out_m = out_m & ~m;
`ifdef GPIO_BANK_IRQ_EN
                3'd5: en_m   = (en_m & ~lane_mask(b)) | m;
                3'd6: edge_m = (edge_m & ~lane_mask(b)) | m;
                3'd7: stat_m = stat_m & ~m;
`endif
                default: ;
            endcase
        end
        check("gpo", {24'b0, gpo}, {24'b0, out_m});
        check("gpoe", {24'b0, gpoe}, {24'b0, dir_m});
        @(negedge clk);
        check("ack_lo", {31'b0, ack}, 32'd0);
    endtask

    logic [7:0] dv [6];
    logic [7:0] held_exp;
    int         ops;

    initial begin
        gpi = 0;
        chg = -100;
        pins_old = 0; pins_new = 0;
        @(negedge clk);
        do_reset();

        // Reset state and all registers
        check("rst_gpoe", {24'b0, gpoe}, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
        check("rst_gpo", {24'b0, gpo}, {24'b0, ORST});
        for (int a = 0; a < 8; a++) wb(1'b0, a[2:0], 4'hF, 32'h0);

        // Write / set / clear sequence
        wb(1'b1, 3'd1, 4'hF, 32'h0000_00A5);
        wb(1'b1, 3'd3, 4'hF, 32'h0000_000F);
        wb(1'b1, 3'd4, 4'hF, 32'h0000_0081);
        wb(1'b0, 3'd1, 4'hF, 32'h0);
        check("set_clr", {24'b0, gpo}, 32'h0000_002E);

        // Byte-gated DIR with upper bits ignored; lane 0 disabled has no effect
        wb(1'b1, 3'd2, 4'b0001, 32'hFFFF_FFFF);
        wb(1'b0, 3'd2, 4'h0, 32'h0);
        wb(1'b1, 3'd2, 4'b1110, 32'h0000_0000);
        wb(1'b0, 3'd2, 4'hF, 32'h0);
        wb(1'b1, 3'd0, 4'hF, 32'hFFFF_FFFF);

        // Input synchroniser latency, both boundaries
        set_pins(8'h08);
        wb(1'b0, 3'd0, 4'hF, 32'h0);
        wb(1'b0, 3'd0, 4'hF, 32'h0);
        set_pins(8'h00);
        @(negedge clk);
        wb(1'b0, 3'd0, 4'hF, 32'h0);
        wb(1'b0, 3'd0, 4'hF, 32'h0);

        // Held strobe: ack every other cycle, write applied only on request edges
        for (int k = 0; k < 6; k++) dv[k] = 8'($urandom);
        held_exp = out_m;
        cyc = 1; stb = 1; we = 1; adr = 3'd1; be = 4'hF;
        for (int k = 0; k < 6; k++) begin
            wdat = {24'b0, dv[k]};
            @(negedge clk);
            if (k % 2 == 0) held_exp = dv[k];
            check($sformatf("held_ack%0d", k), {31'b0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("held_gpo%0d", k), {24'b0, gpo}, {24'b0, held_exp});
        end
        cyc = 0; stb = 0;
        out_m = held_exp;
        @(negedge clk);

`ifdef GPIO_BANK_IRQ_EN
        // Rising-edge interrupt, W1C, and set winning over a same-cycle clear
        set_pins(8'h00);
        wb(1'b1, 3'd5, 4'hF, 32'h08);
        wb(1'b1, 3'd6, 4'hF, 32'h08);
        check("irq_idle", {31'b0, irq}, 32'd0);
        set_pins(8'h08);
        while (cyc_n < chg + SS + 2) @(negedge clk);
        stat_m = 8'h08;
        check("irq_set", {31'b0, irq}, 32'd1);
        wb(1'b0, 3'd7, 4'hF, 32'h0);
        wb(1'b1, 3'd7, 4'hF, 32'h08);
        check("irq_clr", {31'b0, irq}, 32'd0);
        set_pins(8'h00);
        set_pins(8'h08);
        while (cyc_n < chg + SS) @(negedge clk);
        wb(1'b1, 3'd7, 4'hF, 32'h08);
        stat_m = 8'h08;
        wb(1'b0, 3'd7, 4'hF, 32'h0);
        check("irq_win", {31'b0, irq}, 32'd1);
        wb(1'b1, 3'd5, 4'hF, 32'h00);
        @(negedge clk);
        check("irq_masked", {31'b0, irq}, 32'd0);
`else
        // Interrupt registers absent: writes acked and ignored, reads zero
        for (int a = 5; a < 8; a++) begin
            wb(1'b1, a[2:0], 4'hF, 32'hFFFF_FFFF);
            wb(1'b0, a[2:0], 4'hF, 32'h0);
        end
        set_pins(8'hFF);
        set_pins(8'h00);
        repeat (4) @(negedge clk);
        check("irq_tied", {31'b0, irq}, 32'd0);
`endif

        // Randomised traffic against the model
        ops = 0;
        while (ops < 50) begin
            logic [2:0] a;
            if ($urandom_range(0, 4) == 0) set_pins(8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
`ifdef GPIO_BANK_IRQ_EN
            a = 3'($urandom_range(0, 4));
`else
            a = 3'($urandom_range(0, 7));
`endif
            wb(1'($urandom), a, 4'($urandom), $urandom);
            check("irq_rand", {31'b0, irq}, 32'd0);
            ops++;
        end

        // Reset in the middle of a transaction drops the pending ack
        wb(1'b1, 3'd1, 4'hF, {24'b0, ~ORST});
        cyc = 1; stb = 1; we = 0; adr = 3'd1; be = 4'hF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'b0, ack}, 32'd0);
        check("mid_rst_dat", rdat, 32'd0);
        check("mid_rst_gpo", {24'b0, gpo}, {24'b0, ORST});
        cyc = 0; stb = 0;
        @(negedge clk);
        do_reset();
        wb(1'b0, 3'd1, 4'hF, 32'h0);
        wb(1'b0, 3'd2, 4'hF, 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
